// File: rtl/adrv9001_pkg.sv
// Shared definitions for the ADRV9001 TX framer: FSM phases and lane constants.
package adrv9001_pkg;

  localparam int SAMPLE_W = 16;
  localparam int LANE_W   = 8;

  localparam logic [LANE_W-1:0] STRB_PULSE_BYTE = 8'h80;
  localparam logic [LANE_W-1:0] STRB_FULL_BYTE  = 8'hFF;

  // IDLE: lanes quiet, HI: upper bytes on lanes, LO: lower bytes on lanes
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/adrv9001_tx_unpack.sv
// Splits a held {I,Q} sample into per-lane bytes for the current phase and
// builds the strobe byte. Purely combinational; the caller registers it.
module adrv9001_tx_unpack
  import adrv9001_pkg::*;
#(
  parameter bit STROBE_PULSE = 1'b1
) (
  input  fsm_state_t                phase,
  input  logic [2*SAMPLE_W-1:0]     sample,
  output logic [LANE_W-1:0]         i_byte,
  output logic [LANE_W-1:0]         q_byte,
  output logic [LANE_W-1:0]         strb_byte
);

  logic [SAMPLE_W-1:0] i_word;
  logic [SAMPLE_W-1:0] q_word;

  assign i_word = sample[2*SAMPLE_W-1:SAMPLE_W];
  assign q_word = sample[SAMPLE_W-1:0];

  // Pick upper or lower byte per lane; strobe only marks the upper byte.
  always_comb begin
    i_byte    = '0;
    q_byte    = '0;
    strb_byte = '0;
    case (phase)
      HI: begin
        i_byte    = i_word[SAMPLE_W-1 -: LANE_W];
        q_byte    = q_word[SAMPLE_W-1 -: LANE_W];
        strb_byte = STROBE_PULSE ? STRB_PULSE_BYTE : STRB_FULL_BYTE;
      end
      LO: begin
        i_byte = i_word[LANE_W-1:0];
        q_byte = q_word[LANE_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/adrv9001_tx_framer.sv
// ADRV9001/2 LVDS TX framer: takes one {I,Q} sample per two divided-clock
// cycles from an AXI-stream slave and emits MSB-first 8-bit words for the
// I, Q and strobe serializers. Handshake, FSM and underflow counter live here.
module adrv9001_tx_framer
  import adrv9001_pkg::*;
#(
  parameter bit STROBE_PULSE = 1'b1,
  parameter bit IDLE_HOLD    = 1'b0
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_rstn,
  input  logic                  en,
  input  logic [2*SAMPLE_W-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [LANE_W-1:0]     i_out,
  output logic [LANE_W-1:0]     q_out,
  output logic [LANE_W-1:0]     strb_out,
  output logic                  active,
  output logic [15:0]           underflow_cnt
);

  fsm_state_t            state;
  fsm_state_t            state_nxt;
  logic [2*SAMPLE_W-1:0] hold;
  logic [2*SAMPLE_W-1:0] hold_nxt;
  logic                  accept;
  logic                  starve;
  logic [LANE_W-1:0]     i_nxt;
  logic [LANE_W-1:0]     q_nxt;
  logic [LANE_W-1:0]     strb_nxt;

  // Ready only at sample boundaries; held low while reset is asserted.
  assign s_axis_tready = s_axis_rstn && en && ((state == IDLE) || (state == LO));
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign starve        = (state == LO) && en && !s_axis_tvalid;

  // Next phase and sample: HI always completes through LO, so no sample is cut.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = HI;
          hold_nxt  = s_axis_tdata;
        end
      end
      HI: state_nxt = LO;
      LO: begin
        if (accept) begin
          state_nxt = HI;
          hold_nxt  = s_axis_tdata;
        end else if (starve) begin
          state_nxt = IDLE_HOLD ? HI : IDLE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane bytes are derived from the upcoming phase so the outputs register
  // alongside the state and appear one cycle after the accepting edge.
  adrv9001_tx_unpack #(
    .STROBE_PULSE (STROBE_PULSE)
  ) u_unpack (
    .phase     (state_nxt),
    .sample    (hold_nxt),
    .i_byte    (i_nxt),
    .q_byte    (q_nxt),
    .strb_byte (strb_nxt)
  );

  // State, hold register, registered lane outputs and saturating underflow count.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_rstn) begin
      state         <= IDLE;
      hold          <= '0;
      i_out         <= '0;
      q_out         <= '0;
      strb_out      <= '0;
      active        <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold     <= hold_nxt;
      i_out    <= i_nxt;
      q_out    <= q_nxt;
      strb_out <= strb_nxt;
      active   <= (state_nxt != IDLE);
      if (starve && (underflow_cnt != 16'hFFFF)) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

endmodule
